// File: rtl/fpu_mul_arbiter_pkg.sv
// Shared constants for the FP multiplier arbiter: FSM encoding, IEEE-754 single
// field positions and the requester-ID width helper.
package fpu_mul_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;

    // A single requester still needs a 1-bit ID field.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NUM_REQ_DEF = 4;
    localparam int ID_W        = id_width(NUM_REQ_DEF);

endpackage

// File: rtl/fpu_mul_arbiter_if.sv
// Request, multiplier and response bundle between the FPU issue logic, the
// arbiter (slave side) and the shared multiplier.
interface fpu_mul_arbiter_if
    import fpu_mul_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_REQ = 4
);
    localparam int TAG_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*XLEN-1:0] req_a;
    logic [NUM_REQ*XLEN-1:0] req_b;
    logic [XLEN-1:0]         mul_a;
    logic [XLEN-1:0]         mul_b;
    logic [XLEN-1:0]         mul_result;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [TAG_W-1:0]        rsp_id;
    logic [XLEN-1:0]         rsp_result;
    logic                    busy;

    modport slave (
        input  req_valid, req_a, req_b, mul_result, rsp_ready,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_result, busy
    );

    modport master (
        output req_valid, req_a, req_b, mul_result, rsp_ready,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_result, busy
    );

endinterface

// File: rtl/fpu_mul_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter
    import fpu_mul_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDW    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_idx,
    output logic               any_req
);

    int             pos;
    logic [IDW-1:0] idx;

    always_comb begin
        // NOTE: every output gets a default first so no path through the loop infers a latch.
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        pos       = 0;
        idx       = '0;
        // Walk from the farthest offset down so the nearest hit to rr_ptr wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = int'(rr_ptr) + k;
            idx = IDW'((pos >= NUM_REQ) ? pos - NUM_REQ : pos);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = idx;
                any_req    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_mul_arbiter.sv
// Shares one combinational single-precision multiplier between NUM_REQ requesters.
// Optional FPMUL_ARB_ZERO_BYPASS_EN: zero-exponent operands skip the multicycle wait.
module fpu_mul_arbiter
    import fpu_mul_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NUM_REQ    = 4,
    parameter int MUL_CYCLES = 3
) (
    input logic               clk,
    input logic               rst_n,
    fpu_mul_arbiter_if.slave  bus
);

    localparam int IDW   = id_width(NUM_REQ);
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    logic [1:0]         state;
    logic [IDW-1:0]     rr_ptr;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     grant_idx;
    logic               any_req;
    logic [IDW-1:0]     ptr_next;
    logic [XLEN-1:0]    sel_a;
    logic [XLEN-1:0]    sel_b;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req       (bus.req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    assign bus.req_ready = (state == IDLE) ? grant : '0;
    assign bus.busy      = (state != IDLE);

    assign sel_a    = bus.req_a[int'(grant_idx)*XLEN +: XLEN];
    assign sel_b    = bus.req_b[int'(grant_idx)*XLEN +: XLEN];
    assign ptr_next = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;

`ifdef FPMUL_ARB_ZERO_BYPASS_EN
    logic zero_op;
    assign zero_op = (sel_a[EXP_MSB:EXP_LSB] == '0) || (sel_b[EXP_MSB:EXP_LSB] == '0);
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            cnt            <= '0;
            bus.mul_a      <= '0;
            bus.mul_b      <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= '0;
            bus.rsp_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        bus.mul_a  <= sel_a;
                        bus.mul_b  <= sel_b;
                        bus.rsp_id <= grant_idx;
                        rr_ptr     <= ptr_next;
`ifdef FPMUL_ARB_ZERO_BYPASS_EN
                        if (zero_op) begin
                            bus.rsp_result <= {sel_a[SIGN_BIT] ^ sel_b[SIGN_BIT], {(XLEN-1){1'b0}}};
                            bus.rsp_valid  <= 1'b1;
                            state          <= RESP;
                        end else begin
                            cnt   <= CNT_W'(MUL_CYCLES - 1);
                            state <= WAIT;
                        end
`else
                        cnt   <= CNT_W'(MUL_CYCLES - 1);
                        state <= WAIT;
`endif
                    end
                end
                // mul_a/mul_b have been stable for MUL_CYCLES edges when cnt reaches zero.
                WAIT: begin
                    if (cnt == '0) begin
                        bus.rsp_result <= bus.mul_result;
                        bus.rsp_valid  <= 1'b1;
                        state          <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Self-checking bench for fpu_mul_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of grant order, latency and payload.
module tb_fpu_mul_arbiter;

    localparam int XLEN       = 32;
    localparam int NUM_REQ    = 4;
    localparam int MUL_CYCLES = 3;

`ifdef FPMUL_ARB_ZERO_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpu_mul_arbiter_if #(.XLEN(XLEN), .NUM_REQ(NUM_REQ)) bus ();

    fpu_mul_arbiter #(.XLEN(XLEN), .NUM_REQ(NUM_REQ), .MUL_CYCLES(MUL_CYCLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Truncating normal-only multiplier standing in for the real datapath.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        logic        s;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'b0};
        p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
        if (p[47]) return {s, 8'(e + 10'd1), p[46:24]};
        return {s, e[7:0], p[45:23]};
    endfunction

    assign bus.mul_result = fmul(bus.mul_a, bus.mul_b);

    logic [XLEN-1:0] op_a [NUM_REQ];
    logic [XLEN-1:0] op_b [NUM_REQ];

    always_comb begin
        bus.req_a = '0;
        bus.req_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_a[i*XLEN +: XLEN] = op_a[i];
            bus.req_b[i*XLEN +: XLEN] = op_b[i];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model state
    bit          m_busy;
    int          m_age;
    int          m_ptr;
    int          m_id;
    logic [31:0] m_a, m_b;
    bit          m_bypass;
    int          cyc;
    bit          seen;
    int          last_lat;
    logic [31:0] last_result;
    int          last_id;
    int          grant_log[$];
    int          grant_cyc[$];

    function automatic logic [31:0] expect_result();
        if (m_bypass) return {m_a[31] ^ m_b[31], 31'b0};
        return fmul(m_a, m_b);
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_age  = 0;
        m_ptr  = 0;
        seen   = 1'b0;
    endtask

    // One clock: inputs already driven; check at negedge, advance the model after posedge.
    task automatic cycle();
        logic [NUM_REQ-1:0] exp_ready;
        bit accept, finish, found;
        int g, lat, idx;
        exp_ready = '0;
        accept = 1'b0;
        finish = 1'b0;
        found  = 1'b0;
        g      = 0;
        @(negedge clk);
        if (!m_busy) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (m_ptr + k) % NUM_REQ;
                if (!found && bus.req_valid[idx]) begin
                    found = 1'b1;
                    g = idx;
                end
            end
            if (found) exp_ready[g] = 1'b1;
            accept = found;
            check("req_ready_idle", bus.req_ready, exp_ready);
            check("busy_idle", bus.busy, 1'b0);
            check("rsp_valid_idle", bus.rsp_valid, 1'b0);
        end else begin
            lat = m_bypass ? 1 : MUL_CYCLES;
            check("req_ready_busy", bus.req_ready, '0);
            check("busy", bus.busy, 1'b1);
            check("mul_a_stable", bus.mul_a, m_a);
            check("mul_b_stable", bus.mul_b, m_b);
            check("rsp_valid", bus.rsp_valid, m_age >= lat);
            if (m_age >= lat) begin
                check("rsp_id", bus.rsp_id, m_id);
                check("rsp_result", bus.rsp_result, expect_result());
                if (!seen) begin
                    seen        = 1'b1;
                    last_lat    = m_age;
                    last_result = bus.rsp_result;
                    last_id     = int'(bus.rsp_id);
                end
                finish = bus.rsp_ready;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (accept) begin
            m_busy   = 1'b1;
            m_age    = 0;
            m_id     = g;
            m_ptr    = (g + 1) % NUM_REQ;
            m_a      = op_a[g];
            m_b      = op_b[g];
            m_bypass = BYPASS_EN && (op_a[g][30:23] == 8'd0 || op_b[g][30:23] == 8'd0);
            seen     = 1'b0;
            grant_log.push_back(g);
            grant_cyc.push_back(cyc);
            bus.req_valid[g] = 1'b0;
        end else if (m_busy) begin
            m_age++;
            if (finish) m_busy = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, bus.req_ready, '0);
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
        check({tag, "_rsp_id"}, bus.rsp_id, '0);
        check({tag, "_rsp_result"}, bus.rsp_result, '0);
        check({tag, "_mul_a"}, bus.mul_a, '0);
        check({tag, "_mul_b"}, bus.mul_b, '0);
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        op_a[i] = a;
        op_b[i] = b;
        bus.req_valid[i] = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(3) == 0) r[30:23] = 8'd0;
        return r;
    endfunction

    initial begin
        cyc = 0;
        model_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        do_reset();

        // Round-robin with every requester asking continuously
        grant_log.delete();
        grant_cyc.delete();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'h3F800000 + (i << 23), 32'h40000000);
        for (int n = 0; n < 21; n++) begin
            bus.req_valid = '1;
            cycle();
        end
        check("rr_count", grant_log.size(), 5);
        for (int n = 0; n < 5 && n < grant_log.size(); n++) begin
            check("rr_order", grant_log[n], n % NUM_REQ);
            if (n > 0) check("rr_spacing", grant_cyc[n] - grant_cyc[n-1], MUL_CYCLES + 2);
        end
        bus.req_valid = '0;
        repeat (6) cycle();

        // Single op on requester 0: 1.5 * 2.0
        set_req(0, 32'h3FC00000, 32'h40000000);
        repeat (7) cycle();
        check("single_id", last_id, 0);
        check("single_result", last_result, 32'h40400000);
        check("single_latency", last_lat, MUL_CYCLES);

        // Backpressure on requester 2, leaving rr_ptr at 3
        bus.rsp_ready = 1'b0;
        set_req(2, 32'h40400000, 32'h40400000);
        repeat (1 + MUL_CYCLES + 10) cycle();
        check("bp_busy_held", bus.busy, 1'b1);
        check("bp_valid_held", bus.rsp_valid, 1'b1);
        bus.rsp_ready = 1'b1;
        cycle();
        cycle();
        check("bp_released", bus.busy, 1'b0);
        check("bp_result", last_result, 32'h41100000);

        // Pointer at 3, only requester 1 valid: 2.0 * 3.0
        set_req(1, 32'h40000000, 32'h40400000);
        repeat (6) cycle();
        check("skip_grant", grant_log[$], 1);
        check("skip_result", last_result, 32'h40C00000);
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'h3F800000, 32'h3F800000);
        cycle();
        check("skip_ptr_next", grant_log[$], 2);
        bus.req_valid = '0;
        repeat (6) cycle();

        // Reset while waiting on the multiplier (counter at 1)
        set_req(1, 32'h40000000, 32'h40000000);
        cycle();
        bus.req_valid = '0;
        cycle();
        check("mid_wait_age", m_age, 1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        repeat (8) cycle();
        set_req(0, 32'h3F800000, 32'h40000000);
        set_req(2, 32'h3F800000, 32'h40000000);
        cycle();
        check("post_reset_grant", grant_log[$], 0);
        bus.req_valid = '0;
        repeat (6) cycle();

        // Zero operand: latency depends on the bypass option
        set_req(0, 32'h00000000, 32'hC0000000);
        repeat (7) cycle();
        check("zero_result", last_result, 32'h80000000);
        check("zero_latency", last_lat, BYPASS_EN ? 1 : MUL_CYCLES);

        // Randomized traffic with drops and random response backpressure
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_valid[i]) begin
                    if ($urandom_range(15) == 0) bus.req_valid[i] = 1'b0;
                end else if ($urandom_range(2) == 0) begin
                    set_req(i, rand_op(), rand_op());
                end
            end
            bus.rsp_ready = ($urandom_range(2) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_mul_arbiter.md
Name: fpu_mul_arbiter

Overview:
Shares one combinational single-precision multiplier datapath between NUM_REQ requesters.
- Round-robin arbitration with a per-requester valid/ready handshake.
- Operands are registered into the multiplier and held stable for MUL_CYCLES cycles, so the long ripple adder chain is treated as a multicycle path.
- The product is captured and returned on a single valid/ready response channel tagged with the requester ID.
- Sits between the FPU issue logic and the multiplier instance.

Parameters:
XLEN, 32, operand/result width (IEEE-754 single)
NUM_REQ, 4, number of requesters (2..8)
MUL_CYCLES, 3, cycles the multiplier inputs are held before its result is sampled (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_a  in  NUM_REQ*XLEN  operand A, requester i at [i*XLEN +: XLEN]
req_b  in  NUM_REQ*XLEN  operand B, same packing
mul_a  out  XLEN  registered operand to multiplier
mul_b  out  XLEN  registered operand to multiplier
mul_result  in  XLEN  multiplier product (combinational from mul_a/mul_b)
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  ID_W  requester index of response
rsp_result  out  XLEN  product
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: one clock `clk`; reset `rst_n` is asynchronous and active-low. While rst_n=0 all registers clear:
  - state=IDLE, rr_ptr=0, wait counter=0
  - mul_a=mul_b=0, rsp_valid=0, rsp_id=0, rsp_result=0
  - req_ready=0, busy=0
- Reset mid-operation drops the in-flight op silently; no response is ever produced for it.
- FSM states: IDLE, WAIT, RESP.
- IDLE, grant:
  - grant = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … wrapping modulo NUM_REQ.
  - req_ready[grant]=1 combinationally; all other bits 0. All bits are 0 outside IDLE.
- IDLE, accept edge (req_valid&req_ready):
  - mul_a/mul_b <= req_a/req_b slice of grant
  - rsp_id <= grant
  - rr_ptr <= grant+1 (wraps to 0 after NUM_REQ-1)
  - counter <= MUL_CYCLES-1; go to WAIT.
- WAIT: counter decrements each cycle. At the edge where counter==0, rsp_result <= mul_result, rsp_valid <= 1, go to RESP.
- Latency: rsp_valid is high exactly MUL_CYCLES edges after the accept edge.
- mul_a/mul_b change only on an accept edge; they stay stable through WAIT and RESP.
- RESP: rsp_valid, rsp_id and rsp_result are held stable until rsp_ready=1. On that edge rsp_valid <= 0 and state goes to IDLE.
- No grant in the RESP-exit cycle. Best-case throughput is one op per MUL_CYCLES+2 cycles.
- Requester rules: once req_valid rises it must hold req_valid and operands until accepted. Dropping a request before acceptance is legal; the arbiter just skips it.
- No requests in IDLE: no state change; rr_ptr unchanged.
- rsp_ready high while not in RESP: ignored.
- Result arithmetic: none inside the block; the product is passed through unchanged. Sign/exponent/mantissa come only from the multiplier.

Optional Feature:
FPMUL_ARB_ZERO_BYPASS_EN
- Defined: on accept, if either operand's exponent field [30:23]==0, the block skips WAIT.
  - rsp_result <= {a[31]^b[31], 31'b0} and rsp_valid rises on the edge after acceptance (latency 1).
  - mul_a/mul_b are still loaded.
- Undefined: every op takes the full MUL_CYCLES path; zero operands give whatever the multiplier produces.

Decomposition:
- Package fpu_mul_pkg:
  - localparam ID_W = $clog2(NUM_REQ), minimum 1
  - state encoding IDLE=2'd0, WAIT=2'd1, RESP=2'd2
  - field constants EXP_MSB=30, EXP_LSB=23, SIGN_BIT=31
- Sub-module rr_arbiter: inputs req vector and rr_ptr; outputs one-hot grant, grant index and any_req. Purely combinational.
- The FSM, counter and registers stay in fpu_mul_arbiter.

Test Plan:
- Single op: req0 valid, a=0x3FC00000 (1.5), b=0x40000000 (2.0) -> req_ready[0] for one cycle; rsp_valid 3 edges later with rsp_result=0x40400000 and rsp_id=0; mul_a/mul_b stable throughout.
- Round-robin: all 4 requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0 with rsp_id matching; one grant per 5 cycles.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_result/rsp_id held, req_ready all 0, busy=1; on rsp_ready=1, IDLE next cycle.
- Pointer wrap/skip: rr_ptr=3, only req1 valid -> grant 1, rr_ptr becomes 2; a=0x40000000, b=0x40400000 -> 0x40C00000.
- Reset mid-WAIT: deassert rst_n at counter=1 -> all outputs 0 immediately; after release no stray rsp_valid; next op starts from rr_ptr=0.
- Macro on: a=0x00000000, b=0xC0000000 -> rsp_valid 1 edge after accept with result 0x80000000; macro off -> 3-edge latency.
